uart_txrx_engine: RTL

// - Parametrised full-duplex UART engine for the pipelined core's UART peripheral.
// - Independent TX and RX state machines with baud/bit counters, serialiser and 2-flop RX synchroniser.
// - Ready/valid handshakes towards the bus-side register block.
// - Generalises the fixed Idle/Load/Write/Transmit/Receive/Read controller to configurable frame format.

---
 rtl/uart_txrx_engine_if.sv | 31 +++
 rtl/uart_txrx_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_txrx_engine_if.sv
// Handshake/serial bundle between the UART engine and its bus-side register block.
// slave = engine side, master = register block / environment side.
interface uart_txrx_engine_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 txd;
    logic                 rxd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_overrun;
    logic [2:0]           tx_state;
    logic [2:0]           rx_state;

    modport master (
        output tx_data, tx_valid, rxd, rx_ready,
        input  tx_ready, txd, rx_data, rx_valid, rx_frame_err, rx_parity_err,
               rx_overrun, tx_state, rx_state
    );

    modport slave (
        input  tx_data, tx_valid, rxd, rx_ready,
        output tx_ready, txd, rx_data, rx_valid, rx_frame_err, rx_parity_err,
               rx_overrun, tx_state, rx_state
    );
endinterface

// File: rtl/uart_txrx_engine.sv
// Full-duplex UART engine: independent TX/RX FSMs with down-counting baud/bit timers.
// Optional parity bit enabled by defining UART_PARITY_EN.
//
// state   | meaning
// IDLE    | line idle (TX: ready for a word, RX: waiting for a falling edge)
// START   | start bit (RX: half-bit wait, then glitch check)
// DATA    | DATA_BITS data bits, LSB first
// PARITY  | parity bit (only with UART_PARITY_EN)
// STOP    | stop bit(s); RX samples only the first one, mid-bit
module uart_txrx_engine #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input logic               clk,
    input logic               rst,
    uart_txrx_engine_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] BAUD_FULL = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    // ---------------- TX ----------------
    state_t               tx_st, tx_st_nxt;
    logic [BW-1:0]        tx_baud, tx_baud_nxt;
    logic [CW-1:0]        tx_bits, tx_bits_nxt;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_nxt;
    logic                 txd_q, txd_nxt;
    logic                 tx_tc;
`ifdef UART_PARITY_EN
    logic                 tx_par, tx_par_nxt;
`endif

    assign tx_tc = (tx_baud == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_st   <= ST_IDLE;
            tx_baud <= '0;
            tx_bits <= '0;
            tx_sh   <= '0;
            txd_q   <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par  <= 1'b0;
`endif
        end else begin
            tx_st   <= tx_st_nxt;
            tx_baud <= tx_baud_nxt;
            tx_bits <= tx_bits_nxt;
            tx_sh   <= tx_sh_nxt;
            txd_q   <= txd_nxt;
`ifdef UART_PARITY_EN
            tx_par  <= tx_par_nxt;
`endif
        end
    end

    always_comb begin
        tx_st_nxt   = tx_st;
        tx_baud_nxt = tx_baud;
        tx_bits_nxt = tx_bits;
        tx_sh_nxt   = tx_sh;
`ifdef UART_PARITY_EN
        tx_par_nxt  = tx_par;
`endif
        if (tx_st != ST_IDLE)
            tx_baud_nxt = tx_tc ? BAUD_FULL : tx_baud - 1'b1;
        case (tx_st)
            ST_IDLE: if (bus.tx_valid) begin
                tx_st_nxt   = ST_START;
                tx_baud_nxt = BAUD_FULL;
                tx_sh_nxt   = bus.tx_data;
`ifdef UART_PARITY_EN
                tx_par_nxt  = (^bus.tx_data) ^ PAR_ODD;
`endif
            end
            ST_START: if (tx_tc) begin
                tx_st_nxt   = ST_DATA;
                tx_bits_nxt = DATA_LAST;
            end
            ST_DATA: if (tx_tc) begin
                tx_sh_nxt = tx_sh >> 1;
                if (tx_bits == '0) begin
`ifdef UART_PARITY_EN
                    tx_st_nxt   = ST_PARITY;
`else
                    tx_st_nxt   = ST_STOP;
                    tx_bits_nxt = STOP_LAST;
`endif
                end else begin
                    tx_bits_nxt = tx_bits - 1'b1;
                end
            end
            ST_PARITY: if (tx_tc) begin
                tx_st_nxt   = ST_STOP;
                tx_bits_nxt = STOP_LAST;
            end
            ST_STOP: if (tx_tc) begin
                if (tx_bits == '0) tx_st_nxt   = ST_IDLE;
                else               tx_bits_nxt = tx_bits - 1'b1;
            end
            default: tx_st_nxt = ST_IDLE;
        endcase

        // txd is registered from the next state so the pin never glitches on decode
        case (tx_st_nxt)
            ST_START:  txd_nxt = 1'b0;
            ST_DATA:   txd_nxt = tx_sh_nxt[0];
`ifdef UART_PARITY_EN
            ST_PARITY: txd_nxt = tx_par_nxt;
`endif
            default:   txd_nxt = 1'b1;
        endcase
    end

    assign bus.txd      = txd_q;
    assign bus.tx_ready = (tx_st == ST_IDLE);
    assign bus.tx_state = tx_st;

    // ---------------- RX ----------------
    logic                 rx_s1, rx_s2;
    state_t               rx_st, rx_st_nxt;
    logic [BW-1:0]        rx_baud, rx_baud_nxt;
    logic [CW-1:0]        rx_bits, rx_bits_nxt;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_nxt;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_nxt;
    logic                 rx_valid_q, rx_valid_nxt;
    logic                 fe_q, fe_nxt, pe_q, pe_nxt, ov_q, ov_nxt;
    logic                 rx_tc;
`ifdef UART_PARITY_EN
    logic                 par_bad, par_bad_nxt;
`endif

    assign rx_tc = (rx_baud == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_st      <= ST_IDLE;
            rx_baud    <= '0;
            rx_bits    <= '0;
            rx_sh      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            ov_q       <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad    <= 1'b0;
`endif
        end else begin
            rx_s1      <= bus.rxd;
            rx_s2      <= rx_s1;
            rx_st      <= rx_st_nxt;
            rx_baud    <= rx_baud_nxt;
            rx_bits    <= rx_bits_nxt;
            rx_sh      <= rx_sh_nxt;
            rx_data_q  <= rx_data_nxt;
            rx_valid_q <= rx_valid_nxt;
            fe_q       <= fe_nxt;
            pe_q       <= pe_nxt;
            ov_q       <= ov_nxt;
`ifdef UART_PARITY_EN
            par_bad    <= par_bad_nxt;
`endif
        end
    end

    always_comb begin
        rx_st_nxt    = rx_st;
        rx_baud_nxt  = rx_baud;
        rx_bits_nxt  = rx_bits;
        rx_sh_nxt    = rx_sh;
        rx_data_nxt  = rx_data_q;
        rx_valid_nxt = rx_valid_q;
        fe_nxt       = 1'b0;
        pe_nxt       = 1'b0;
        ov_nxt       = 1'b0;
`ifdef UART_PARITY_EN
        par_bad_nxt  = par_bad;
`endif
        if (rx_valid_q && bus.rx_ready)
            rx_valid_nxt = 1'b0;
        if (rx_st != ST_IDLE)
            rx_baud_nxt = rx_tc ? BAUD_FULL : rx_baud - 1'b1;
        case (rx_st)
            ST_IDLE: if (!rx_s2) begin
                rx_st_nxt   = ST_START;
                rx_baud_nxt = BAUD_HALF;
`ifdef UART_PARITY_EN
                par_bad_nxt = 1'b0;
`endif
            end
            ST_START: if (rx_tc) begin
                if (rx_s2) begin
                    rx_st_nxt   = ST_IDLE;
                end else begin
                    rx_st_nxt   = ST_DATA;
                    rx_bits_nxt = DATA_LAST;
                end
            end
            ST_DATA: if (rx_tc) begin
                rx_sh_nxt = {rx_s2, rx_sh[DATA_BITS-1:1]};
                if (rx_bits == '0) begin
`ifdef UART_PARITY_EN
                    rx_st_nxt = ST_PARITY;
`else
                    rx_st_nxt = ST_STOP;
`endif
                end else begin
                    rx_bits_nxt = rx_bits - 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: if (rx_tc) begin
                par_bad_nxt = rx_s2 ^ (^rx_sh) ^ PAR_ODD;
                rx_st_nxt   = ST_STOP;
            end
`endif
            // Return to IDLE at mid-stop so the next start edge is never missed
            ST_STOP: if (rx_tc) begin
                rx_st_nxt = ST_IDLE;
                if (!rx_s2) begin
                    fe_nxt = 1'b1;
`ifdef UART_PARITY_EN
                end else if (par_bad) begin
                    pe_nxt = 1'b1;
`endif
                end else if (rx_valid_q && !bus.rx_ready) begin
                    ov_nxt = 1'b1;
                end else begin
                    rx_data_nxt  = rx_sh;
                    rx_valid_nxt = 1'b1;
                end
            end
            default: rx_st_nxt = ST_IDLE;
        endcase
    end

    assign bus.rx_data      = rx_data_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.rx_frame_err = fe_q;
    assign bus.rx_overrun   = ov_q;
    assign bus.rx_state     = rx_st;
`ifdef UART_PARITY_EN
    assign bus.rx_parity_err = pe_q;
`else
    // Without parity the flag is a constant zero; PAR_ODD only folds away here
    assign bus.rx_parity_err = pe_q & PAR_ODD & 1'b0;
`endif
endmodule
